// File: rtl/i2s_defs_pkg.sv
// Definitions shared by the I2S receive and transmit paths.
`timescale 1ns/1ps
package i2s_defs;

  localparam int I2S_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } i2s_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Basic flop plus a codec-input synchronizer with rise/fall detection.
`timescale 1ns/1ps
module dff (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);
  always_ff @(posedge i_clk) begin
    if (i_reset) o_q <= 1'b0;
    else         o_q <= i_d;
  end
endmodule

module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  // Chain of STAGES synchronizer flops followed by one delay flop for edge detection
  logic [STAGES+1:0] w_chain;

  assign w_chain[0] = i_async;

  for (genvar g = 0; g <= STAGES; g++) begin : g_ff
    dff u_ff (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_d    (w_chain[g]),
      .o_q    (w_chain[g+1])
    );
  end

  assign o_level = w_chain[STAGES];
  assign o_rise  = w_chain[STAGES] & ~w_chain[STAGES+1];
  assign o_fall  = ~w_chain[STAGES] & w_chain[STAGES+1];
endmodule

// File: rtl/i2s_line_in_rx.sv
// I2S line-in receiver: oversamples codec bclk/lr/sdata on clk_100 and
// delivers left/right sample pairs with a one-cycle new_sample strobe.
`timescale 1ns/1ps
module i2s_line_in_rx
  import i2s_defs::*;
#(
  parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_100,
  input  logic                  reset,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lr,
  input  logic                  i2s_sdata,
  output logic [DATA_WIDTH-1:0] line_in_l,
  output logic [DATA_WIDTH-1:0] line_in_r,
  output logic                  new_sample,
  output logic                  frame_err
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic w_bclk_lvl, w_bclk_rise, w_bclk_fall;
  logic w_lr_lvl, w_lr_rise, w_lr_fall;
  logic w_sd_lvl, w_sd_rise, w_sd_fall;
  logic w_unused, w_lr_edge, w_last, w_shift, w_err;
  logic [DATA_WIDTH-1:0] w_word;
  i2s_state_t r_state, w_next;

  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift, r_hold_l, r_line_l, r_line_r;
  logic                  r_left_ok, r_new_sample, r_frame_err;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .i_clk(clk_100), .i_reset(reset), .i_async(i2s_bclk),
    .o_level(w_bclk_lvl), .o_rise(w_bclk_rise), .o_fall(w_bclk_fall));
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lr (
    .i_clk(clk_100), .i_reset(reset), .i_async(i2s_lr),
    .o_level(w_lr_lvl), .o_rise(w_lr_rise), .o_fall(w_lr_fall));
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sd (
    .i_clk(clk_100), .i_reset(reset), .i_async(i2s_sdata),
    .o_level(w_sd_lvl), .o_rise(w_sd_rise), .o_fall(w_sd_fall));

  assign w_unused  = &{1'b0, w_bclk_lvl, w_bclk_fall, w_sd_rise, w_sd_fall};
  assign w_lr_edge = w_lr_rise | w_lr_fall;
  assign w_last    = (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_word    = {r_shift[DATA_WIDTH-2:0], w_sd_lvl};

  always_ff @(posedge clk_100) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // An LR edge wins over a same-cycle bclk rise; that rise then serves as the skip bit
  always_comb begin
    w_next  = r_state;
    w_shift = 1'b0;
    w_err   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_lr_fall) w_next = w_bclk_rise ? ST_SHIFT : ST_SKIP;
      end
      ST_SKIP: begin
        if (w_lr_edge)        w_next = w_bclk_rise ? ST_SHIFT : ST_SKIP;
        else if (w_bclk_rise) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_lr_edge) begin
          w_err  = 1'b1;
          w_next = w_bclk_rise ? ST_SHIFT : ST_SKIP;
        end else if (w_bclk_rise) begin
          w_shift = 1'b1;
          if (w_last) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_lr_edge) w_next = w_bclk_rise ? ST_SHIFT : ST_SKIP;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_hold_l     <= '0;
      r_line_l     <= '0;
      r_line_r     <= '0;
      r_left_ok    <= 1'b0;
      r_new_sample <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_new_sample <= 1'b0;
      r_frame_err  <= w_err & ~r_frame_err;
      if (w_shift)                              r_cnt <= r_cnt + 1'b1;
      else if (r_state != ST_SHIFT || w_lr_edge) r_cnt <= '0;
      if (w_err) begin
        r_shift   <= '0;
        r_left_ok <= 1'b0;
      end else if (w_shift) begin
        r_shift <= w_word;
        if (w_last) begin
          if (!w_lr_lvl) begin
            r_hold_l  <= w_word;
            r_left_ok <= 1'b1;
          end else begin
            // Right word publishes the pair only when this frame's left word is intact
            if (r_left_ok) begin
              r_line_l     <= r_hold_l;
              r_line_r     <= w_word;
              r_new_sample <= 1'b1;
            end
            r_left_ok <= 1'b0;
          end
        end
      end
    end
  end

  assign line_in_l  = r_line_l;
  assign line_in_r  = r_line_r;
  assign new_sample = r_new_sample;
  assign frame_err  = r_frame_err;
endmodule

// File: doc/i2s_line_in_rx.md
I2S_LINE_IN_RX -- requirements
Module: i2s_line_in_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, meaning captured bits per channel (MSB-first).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning flops per synchronizer on each codec input.
REQ-003 The block SHALL have port clk_100  input  1  system clock (100 MHz); all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port i2s_bclk  input  1  codec bit clock (AC_GPIO2), asynchronous to clk_100.
REQ-006 The block SHALL have port i2s_lr  input  1  codec channel clock (AC_GPIO3), 0 = left, 1 = right.
REQ-007 The block SHALL have port i2s_sdata  input  1  codec ADC serial data (AC_GPIO1).
REQ-008 The block SHALL have port line_in_l  output  DATA_WIDTH  last complete left sample.
REQ-009 The block SHALL have port line_in_r  output  DATA_WIDTH  last complete right sample.
REQ-010 The block SHALL have port new_sample  output  1  one-cycle pulse: line_in_l/r updated together.
REQ-011 The block SHALL have port frame_err  output  1  one-cycle pulse: channel word truncated by an early LR edge.

Function
REQ-012 All three codec inputs SHALL pass through SYNC_STAGES flops; edge detection SHALL compare the synchronized value with one further delayed copy.
REQ-013 Bits SHALL be sampled only in the cycle a synchronized bclk rising edge is detected; bclk falling edges SHALL be ignored.
REQ-014 States SHALL be IDLE, SKIP, SHIFT, DRAIN.
REQ-015 IDLE: wait for a synchronized LR falling edge (left start), then go to SKIP; no capture in IDLE.
REQ-016 SKIP: discard the first bclk rising edge after an LR edge (I2S one-bit delay), then go to SHIFT with bit counter 0.
REQ-017 SHIFT: shift i2s_sdata into a DATA_WIDTH shift register MSB-first on each bclk rising edge; after DATA_WIDTH bits, latch the word into the channel holding register selected by the current LR and go to DRAIN.
REQ-018 DRAIN: ignore remaining slot bits (slot width from DATA_WIDTH+1 up to 32 or more) until the next LR edge, then go to SKIP.
REQ-019 When the right word completes in SHIFT, line_in_l and line_in_r SHALL both update and new_sample SHALL pulse high in the following clk_100 cycle, only if the left word of the same frame also completed.
REQ-020 An LR edge detected in SHIFT before DATA_WIDTH bits SHALL pulse frame_err, discard the partial word, invalidate the current frame (no new_sample), and go to SKIP for the new channel.
REQ-021 If an LR edge and a bclk rising edge are detected in the same cycle, the LR edge SHALL take priority and the bclk edge SHALL count as the SKIP bit of the new channel.
REQ-022 A slot of exactly DATA_WIDTH+1 bclk periods SHALL capture correctly with no frame_err.
REQ-023 Output registers SHALL hold their values between new_sample pulses; data SHALL be passed raw (two's complement, no sign conversion).
REQ-024 new_sample and frame_err SHALL never be high for more than one consecutive cycle.

Reset
REQ-025 On reset: state IDLE, counter 0, shift/holding registers 0, line_in_l = 0, line_in_r = 0, new_sample = 0, frame_err = 0, synchronizer flops 0.
REQ-026 Reset mid-word SHALL abandon the word; capture SHALL restart only at the next LR falling edge after reset deasserts.

Structure
REQ-027 State encodings and default DATA_WIDTH SHALL live in a shared header i2s_defs, also used by the codec transmit path.
REQ-028 The synchronizer plus edge detector SHALL be one sub-module, i2s_sync_edge (built from the codebase dff), instantiated per input (rise/fall outputs).
REQ-029 Total RTL SHALL be 120-400 lines; no FIFO, no clock-domain logic beyond the synchronizers.

Verification
REQ-030 64-bclk frames at 3.072 MHz, left 24'hA5A5A5, right 24'h5A5A5A -> line_in_l = A5A5A5, line_in_r = 5A5A5A, exactly one new_sample per frame.
REQ-031 Left 24'h800001, right 24'h7FFFFF in 32-bit slots -> values passed bit-exact, trailing 8 bits ignored, frame_err never high.
REQ-032 Stream started mid-right-channel -> no new_sample until the first full left+right pair after an LR falling edge.
REQ-033 LR toggles after 10 left bits -> frame_err pulses once, no new_sample that frame, next clean frame captured correctly.
REQ-034 Reset asserted mid-left-word -> all outputs 0 next cycle, next new_sample carries only post-reset frame data.
REQ-035 25-bclk slots (DATA_WIDTH+1) with LR edge coincident with a detected bclk rise -> correct capture, no frame_err.
